// File: rtl/csr_access_ctrl_if.sv
// Core-side CSR request/response channel between the execute stage and csr_access_ctrl.
// The master modport is the execute stage; the slave modport is the sequencer.
interface csr_access_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_src_zero_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_illegal_o;

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_src_zero_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_src_zero_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// Zicsr read-modify-write sequencer in front of a CSR file, with round-robin
// arbitration against sticky FPU exception-flag merges into fflags.
module csr_access_ctrl #(
  parameter logic [11:0] NOP_WADDR   = 12'h000,
  parameter logic [11:0] FFLAGS_ADDR = 12'h001
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  csr_access_ctrl_if.slave        bus,
  input  logic                    fpu_flags_valid_i,
  input  logic [4:0]              fpu_flags_i,
  output logic [11:0]             csr_raddr_o,
  input  logic [31:0]             csr_rdata_i,
  output logic [11:0]             csr_waddr_o,
  output logic [31:0]             csr_wdata_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
  localparam logic GRANT_CORE = 1'b0;
  localparam logic GRANT_FPU  = 1'b1;

  state_t      r_state;
  logic [4:0]  r_pend;
  logic        r_last_grant;
  logic        r_owner_fpu;
  logic [1:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_src_zero;
  logic        r_illegal;
  logic [31:0] r_old;

  state_t      w_state_next;
  logic [4:0]  w_pend_next;
  logic        w_pend_clear;
  logic        w_grant_core;
  logic        w_grant_fpu;
  logic        w_fcsr_hit;
  logic        w_write_intent;
  logic        w_illegal;
  logic        w_core_cand;
  logic        w_fpu_cand;

  always_comb begin
    w_state_next   = r_state;
    w_grant_core   = 1'b0;
    w_grant_fpu    = 1'b0;
    w_core_cand    = bus.req_valid_i;
    w_fpu_cand     = (r_pend != 5'd0);
    w_fcsr_hit     = (bus.req_addr_i >= 12'h001) && (bus.req_addr_i <= 12'h003);
    w_write_intent = (bus.req_op_i == OP_RW) ||
                     (((bus.req_op_i == OP_RS) || (bus.req_op_i == OP_RC)) && !bus.req_src_zero_i);
    w_illegal      = (bus.req_op_i == 2'b00) ||
                     ((bus.req_addr_i[11:10] == 2'b11) && w_write_intent);
    w_pend_clear   = (r_state == WR) && r_owner_fpu;
    w_pend_next    = (w_pend_clear ? 5'd0 : r_pend) | (fpu_flags_valid_i ? fpu_flags_i : 5'd0);

    bus.req_ready_o   = 1'b0;
    bus.rsp_valid_o   = 1'b0;
    bus.rsp_rdata_o   = 32'd0;
    bus.rsp_illegal_o = 1'b0;
    csr_raddr_o       = 12'd0;
    csr_waddr_o       = NOP_WADDR;
    csr_wdata_o       = 32'd0;
    busy_o            = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        // An fflags/frm/fcsr access must observe any pending flags, so the merge goes first.
        if (w_core_cand && w_fpu_cand) begin
          if (w_fcsr_hit || (r_last_grant == GRANT_CORE)) w_grant_fpu = 1'b1;
          else                                           w_grant_core = 1'b1;
        end else if (w_core_cand) begin
          w_grant_core = 1'b1;
        end else if (w_fpu_cand) begin
          w_grant_fpu = 1'b1;
        end
        bus.req_ready_o = w_grant_core;
        if (w_grant_core)     w_state_next = w_illegal ? RSP : RD;
        else if (w_grant_fpu) w_state_next = RD;
      end
      RD: begin
        csr_raddr_o = r_owner_fpu ? FFLAGS_ADDR : r_addr;
        if (r_owner_fpu)                      w_state_next = WR;
        else if (r_op[1] && r_src_zero)       w_state_next = RSP;
        else                                  w_state_next = WR;
      end
      WR: begin
        if (r_owner_fpu) begin
          csr_waddr_o  = FFLAGS_ADDR;
          csr_wdata_o  = {27'd0, r_old[4:0] | r_pend};
          w_state_next = IDLE;
        end else begin
          csr_waddr_o = r_addr;
          case (r_op)
            OP_RS:   csr_wdata_o = r_old | r_wdata;
            OP_RC:   csr_wdata_o = r_old & ~r_wdata;
            default: csr_wdata_o = r_wdata;
          endcase
          w_state_next = RSP;
        end
      end
      RSP: begin
        bus.rsp_valid_o   = 1'b1;
        bus.rsp_rdata_o   = r_old;
        bus.rsp_illegal_o = r_illegal;
        if (bus.rsp_ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state      <= IDLE;
      r_pend       <= 5'd0;
      r_last_grant <= GRANT_FPU;
      r_owner_fpu  <= 1'b0;
      r_op         <= 2'd0;
      r_addr       <= 12'd0;
      r_wdata      <= 32'd0;
      r_src_zero   <= 1'b0;
      r_illegal    <= 1'b0;
      r_old        <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      if (w_grant_core) begin
        r_owner_fpu  <= 1'b0;
        r_last_grant <= GRANT_CORE;
        r_op         <= bus.req_op_i;
        r_addr       <= bus.req_addr_i;
        r_wdata      <= bus.req_wdata_i;
        r_src_zero   <= bus.req_src_zero_i;
        r_illegal    <= w_illegal;
        r_old        <= 32'd0;
      end else if (w_grant_fpu) begin
        r_owner_fpu  <= 1'b1;
        r_last_grant <= GRANT_FPU;
      end
      if (r_state == RD) r_old <= csr_rdata_i;
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a small behavioural CSR file
// (fcsr at 0x003 reads back as {frm, fflags}).
module tb_csr_access_ctrl;

  logic        clk_i;
  logic        reset_i;
  logic        fpu_flags_valid_i;
  logic [4:0]  fpu_flags_i;
  logic [11:0] csr_raddr_o;
  logic [31:0] csr_rdata_i;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        busy_o;

  csr_access_ctrl_if bus ();

  csr_access_ctrl dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .bus               (bus),
    .fpu_flags_valid_i (fpu_flags_valid_i),
    .fpu_flags_i       (fpu_flags_i),
    .csr_raddr_o       (csr_raddr_o),
    .csr_rdata_i       (csr_rdata_i),
    .csr_waddr_o       (csr_waddr_o),
    .csr_wdata_o       (csr_wdata_o),
    .busy_o            (busy_o)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:4095];
  logic [31:0] wlog [0:63];
  int          wr_count = 0;
  int          rd_count = 0;
  logic [11:0] last_waddr;
  logic [31:0] last_wdata;
  logic [11:0] last_raddr;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  assign csr_rdata_i = (csr_raddr_o == 12'h003) ? {24'd0, mem[2][2:0], mem[1][4:0]} : mem[csr_raddr_o];

  // CSR file model: a write is any cycle whose write address is not the NOP address.
  always @(negedge clk_i) begin
    if (csr_waddr_o != 12'h000) begin
      mem[csr_waddr_o] = csr_wdata_o;
      wlog[wr_count % 64] = csr_wdata_o;
      wr_count++;
      last_waddr = csr_waddr_o;
      last_wdata = csr_wdata_o;
    end
    if (csr_raddr_o != 12'h000) begin
      rd_count++;
      last_raddr = csr_raddr_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic sz, output bit ok, output int waits);
    ok = 1'b0;
    waits = 0;
    bus.req_valid_i = 1'b1;
    bus.req_op_i = op;
    bus.req_addr_i = addr;
    bus.req_wdata_i = wd;
    bus.req_src_zero_i = sz;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req_ready_o) begin
        ok = 1'b1;
        waits = i;
        break;
      end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.rsp_valid_o) break;
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic consume;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_o); end
    total++; if (bus.rsp_rdata_o !== 32'd0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata_o); end
    total++; if (bus.rsp_illegal_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_illegal: got %b want 0", bus.rsp_illegal_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (csr_waddr_o !== 12'h000) begin bad++; $display("FAIL reset_waddr: got %h want 000", csr_waddr_o); end
    total++; if (csr_wdata_o !== 32'd0) begin bad++; $display("FAIL reset_wdata: got %h want 0", csr_wdata_o); end
    total++; if (csr_raddr_o !== 12'h000) begin bad++; $display("FAIL reset_raddr: got %h want 000", csr_raddr_o); end
    reset_i = 1'b1;
    @(negedge clk_i);
    $display("reset: released");
  endtask

  task automatic test_csrrw;
    bit ok; int waits; int lat; int w0;
    mem[12'h300] = 32'h0000_1800;
    w0 = wr_count;
    issue(2'b01, 12'h300, 32'h0000_0088, 1'b0, ok, waits);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rw_accept: got %b want 1", ok); end
    wait_rsp(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL rw_latency: got %0d want 3", lat); end
    total++; if (bus.rsp_rdata_o !== 32'h0000_1800) begin bad++; $display("FAIL rw_rdata: got %h want 00001800", bus.rsp_rdata_o); end
    total++; if (wr_count - w0 != 1) begin bad++; $display("FAIL rw_write_count: got %0d want 1", wr_count - w0); end
    total++; if (last_waddr !== 12'h300 || last_wdata !== 32'h88) begin bad++; $display("FAIL rw_write: got %h/%h want 300/00000088", last_waddr, last_wdata); end
    consume();
    $display("csrrw 0x300 <- 0x88: rdata=%h lat=%0d", 32'h1800, lat);
  endtask

  task automatic test_csrrs_readonly;
    bit ok; int waits; int lat; int w0; int r0;
    mem[12'hC00] = 32'h0000_ABCD;
    w0 = wr_count; r0 = rd_count;
    issue(2'b10, 12'hC00, 32'd0, 1'b1, ok, waits);
    wait_rsp(lat);
    total++; if (lat != 2) begin bad++; $display("FAIL rs_cycle_latency: got %0d want 2", lat); end
    total++; if (bus.rsp_rdata_o !== 32'h0000_ABCD) begin bad++; $display("FAIL rs_cycle_rdata: got %h want 0000abcd", bus.rsp_rdata_o); end
    total++; if (bus.rsp_illegal_o !== 1'b0) begin bad++; $display("FAIL rs_cycle_illegal: got %b want 0", bus.rsp_illegal_o); end
    total++; if (wr_count - w0 != 0) begin bad++; $display("FAIL rs_cycle_writes: got %0d want 0", wr_count - w0); end
    total++; if (rd_count - r0 != 1 || last_raddr !== 12'hC00) begin bad++; $display("FAIL rs_cycle_read: got %0d/%h want 1/c00", rd_count - r0, last_raddr); end
    consume();
    $display("csrrs cycle (x0): rdata=%h", 32'hABCD);
  endtask

  task automatic test_illegal;
    bit ok; int waits; int lat; int w0; int r0;
    w0 = wr_count; r0 = rd_count;
    issue(2'b11, 12'hC02, 32'd1, 1'b0, ok, waits);
    wait_rsp(lat);
    total++; if (lat != 1) begin bad++; $display("FAIL ill_latency: got %0d want 1", lat); end
    total++; if (bus.rsp_illegal_o !== 1'b1) begin bad++; $display("FAIL ill_flag: got %b want 1", bus.rsp_illegal_o); end
    total++; if (bus.rsp_rdata_o !== 32'd0) begin bad++; $display("FAIL ill_rdata: got %h want 0", bus.rsp_rdata_o); end
    repeat (3) @(negedge clk_i);
    #1;
    total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL ill_hold: got %b want 1", bus.rsp_valid_o); end
    total++; if (wr_count - w0 != 0 || rd_count - r0 != 0) begin bad++; $display("FAIL ill_access: got wr=%0d rd=%0d want 0/0", wr_count - w0, rd_count - r0); end
    consume();
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ill_release: got busy=%b want 0", busy_o); end
    $display("csrrc 0xc02 (ro write): illegal response");
  endtask

  task automatic test_csrrc;
    bit ok; int waits; int lat;
    mem[12'h300] = 32'h0000_00FF;
    issue(2'b11, 12'h300, 32'h0000_000F, 1'b0, ok, waits);
    wait_rsp(lat);
    total++; if (last_waddr !== 12'h300 || last_wdata !== 32'h0000_00F0) begin bad++; $display("FAIL rc_wdata: got %h/%h want 300/000000f0", last_waddr, last_wdata); end
    total++; if (bus.rsp_rdata_o !== 32'h0000_00FF) begin bad++; $display("FAIL rc_rdata: got %h want 000000ff", bus.rsp_rdata_o); end
    consume();
    $display("csrrc 0x300 0x0f: wrote %h", last_wdata);
  endtask

  task automatic test_fpu_merge;
    int w0; bit seen_busy;
    mem[12'h001] = 32'h0000_0004;
    w0 = wr_count;
    fpu_flags_valid_i = 1'b1; fpu_flags_i = 5'b00001;
    @(negedge clk_i);
    fpu_flags_i = 5'b10000;
    @(negedge clk_i);
    fpu_flags_valid_i = 1'b0; fpu_flags_i = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (wr_count != w0) break;
      @(negedge clk_i);
    end
    seen_busy = 1'b0;
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (busy_o) seen_busy = 1'b1;
      @(negedge clk_i);
    end
    total++; if (wr_count - w0 != 1) begin bad++; $display("FAIL merge_count: got %0d want 1", wr_count - w0); end
    total++; if (last_waddr !== 12'h001 || last_wdata !== 32'h0000_0015) begin bad++; $display("FAIL merge_data: got %h/%h want 001/00000015", last_waddr, last_wdata); end
    total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL merge_pend_cleared: got busy=%b want 0", seen_busy); end
    $display("fpu merge: fflags <- %h", last_wdata);
  endtask

  task automatic test_fpu_priority;
    bit ok; int waits; int lat; int w0;
    mem[12'h001] = 32'h0000_0015;
    mem[12'h002] = 32'h0000_0003;
    w0 = wr_count;
    fpu_flags_valid_i = 1'b1; fpu_flags_i = 5'b00010;
    @(negedge clk_i);
    fpu_flags_valid_i = 1'b0; fpu_flags_i = 5'd0;
    issue(2'b10, 12'h003, 32'd0, 1'b1, ok, waits);
    total++; if (waits != 3) begin bad++; $display("FAIL prio_wait: got %0d want 3", waits); end
    wait_rsp(lat);
    total++; if (bus.rsp_rdata_o !== 32'h0000_0077) begin bad++; $display("FAIL prio_rdata: got %h want 00000077", bus.rsp_rdata_o); end
    total++; if (wr_count - w0 != 1 || wlog[w0 % 64] !== 32'h0000_0017) begin bad++; $display("FAIL prio_merge: got %0d/%h want 1/00000017", wr_count - w0, wlog[w0 % 64]); end
    consume();
    $display("fcsr read after merge: rdata=%h", 32'h77);
  endtask

  task automatic test_flag_in_wr;
    int w0;
    mem[12'h001] = 32'd0;
    w0 = wr_count;
    fpu_flags_valid_i = 1'b1; fpu_flags_i = 5'b00001;
    @(negedge clk_i);
    fpu_flags_valid_i = 1'b0; fpu_flags_i = 5'd0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (csr_waddr_o == 12'h001) break;
      @(negedge clk_i);
    end
    fpu_flags_valid_i = 1'b1; fpu_flags_i = 5'b01000;
    @(negedge clk_i);
    fpu_flags_valid_i = 1'b0; fpu_flags_i = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (wr_count - w0 >= 2) break;
      @(negedge clk_i);
    end
    repeat (4) @(negedge clk_i);
    total++; if (wr_count - w0 != 2) begin bad++; $display("FAIL wrflag_count: got %0d want 2", wr_count - w0); end
    total++; if (wlog[w0 % 64] !== 32'h0000_0001) begin bad++; $display("FAIL wrflag_first: got %h want 00000001", wlog[w0 % 64]); end
    total++; if (wlog[(w0 + 1) % 64] !== 32'h0000_0009) begin bad++; $display("FAIL wrflag_second: got %h want 00000009", wlog[(w0 + 1) % 64]); end
    $display("flag during merge write: two merges, final fflags=%h", 32'h9);
  endtask

  task automatic test_reset_in_wr;
    bit ok; int waits; int w0; bit seen_busy;
    mem[12'h300] = 32'h0000_00F0;
    issue(2'b01, 12'h300, 32'h0000_0055, 1'b0, ok, waits);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (csr_waddr_o == 12'h300) break;
      @(negedge clk_i);
    end
    total++; if (csr_waddr_o !== 12'h300) begin bad++; $display("FAIL rstwr_reach_wr: got %h want 300", csr_waddr_o); end
    reset_i = 1'b0;
    fpu_flags_valid_i = 1'b1; fpu_flags_i = 5'b00100;
    w0 = wr_count;
    @(negedge clk_i);
    fpu_flags_valid_i = 1'b0; fpu_flags_i = 5'd0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstwr_idle: got busy=%b want 0", busy_o); end
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rstwr_rsp_valid: got %b want 0", bus.rsp_valid_o); end
    reset_i = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      #1;
      if (busy_o) seen_busy = 1'b1;
    end
    total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL rstwr_pend_cleared: got busy=%b want 0", seen_busy); end
    total++; if (wr_count - w0 != 0) begin bad++; $display("FAIL rstwr_no_write: got %0d want 0", wr_count - w0); end
    $display("reset during WR: transaction abandoned");
  endtask

  initial begin
    reset_i = 1'b0;
    fpu_flags_valid_i = 1'b0;
    fpu_flags_i = 5'd0;
    bus.req_valid_i = 1'b0;
    bus.req_op_i = 2'b00;
    bus.req_addr_i = 12'd0;
    bus.req_wdata_i = 32'd0;
    bus.req_src_zero_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    for (int i = 0; i < 64; i++) wlog[i] = 32'd0;
    @(negedge clk_i);
    test_reset();
    test_csrrw();
    test_csrrs_readonly();
    test_illegal();
    test_csrrc();
    test_fpu_merge();
    test_fpu_priority();
    test_flag_in_wr();
    test_reset_in_wr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
